// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control FSM: decodes the opcode, sequences datapath enables and
// mux selects, and runs the memory handshake with a bounded wait.
module main_control_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_write_ncond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [3:0] alu_op,
  output logic       illegal_op,
  output logic       bus_error,
  output logic [3:0] state
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StFetch  = 4'd1;
  localparam logic [3:0] StDecode = 4'd2;
  localparam logic [3:0] StMemAdr = 4'd3;
  localparam logic [3:0] StMemRd  = 4'd4;
  localparam logic [3:0] StMemWb  = 4'd5;
  localparam logic [3:0] StMemWr  = 4'd6;
  localparam logic [3:0] StExR    = 4'd7;
  localparam logic [3:0] StRwb    = 4'd8;
  localparam logic [3:0] StExI    = 4'd9;
  localparam logic [3:0] StIwb    = 4'd10;
  localparam logic [3:0] StBranch = 4'd11;
  localparam logic [3:0] StJump   = 4'd12;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  logic [3:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wait_state;
  logic            timeout;

  assign wait_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  // A ready memory on the last allowed cycle still completes normally.
  assign timeout    = (TIMEOUT_CYCLES != 0) && wait_state && !mem_ready &&
                      (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d        = state_q;
    pc_write       = 1'b0;
    pc_write_cond  = 1'b0;
    pc_write_ncond = 1'b0;
    i_or_d         = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    ir_write       = 1'b0;
    mem_to_reg     = 1'b0;
    reg_dst        = 1'b0;
    reg_write      = 1'b0;
    alu_src_a      = 1'b0;
    alu_src_b      = 2'b00;
    pc_source      = 2'b00;
    alu_op         = 4'b0000;
    illegal_op     = 1'b0;
    bus_error      = timeout;

    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready)    state_d = StDecode;
        else if (timeout) state_d = StFetch;
      end
      StDecode: begin
        alu_src_b = 2'b11;
        case (opcode)
          OpRtype:                                 state_d = StExR;
          OpLw, OpSw:                              state_d = StMemAdr;
          OpBeq, OpBne:                            state_d = StBranch;
          OpJ:                                     state_d = StJump;
          OpAddi, OpSlti, OpAndi, OpOri, OpLui:    state_d = StExI;
          default: begin
            illegal_op = 1'b1;
            state_d    = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready)    state_d = StMemWb;
        else if (timeout) state_d = StFetch;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        mem_write = !timeout;
        i_or_d    = 1'b1;
        if (mem_ready || timeout) state_d = StFetch;
      end
      StExR: begin
        alu_src_a = 1'b1;
        alu_op    = 4'b0010;
        state_d   = StRwb;
      end
      StRwb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = StFetch;
      end
      StExI: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (opcode)
          OpSlti:  alu_op = 4'b0110;
          OpAndi:  alu_op = 4'b0011;
          OpOri:   alu_op = 4'b0101;
          OpLui:   alu_op = 4'b0100;
          default: alu_op = 4'b0000;
        endcase
        state_d = StIwb;
      end
      StIwb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a      = 1'b1;
        alu_op         = 4'b0001;
        pc_source      = 2'b01;
        pc_write_cond  = (opcode == OpBeq);
        pc_write_ncond = (opcode == OpBne);
        state_d        = StFetch;
      end
      StJump: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  // Counting continues only while parked in the same wait state; entry or retry clears it.
  always_comb begin
    cnt_d = '0;
    if (wait_state && (state_d == state_q) && !timeout) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Bench for main_control_fsm: directed scenarios with literal expectations, then random
// traffic compared every cycle against a route-queue model of the instruction flow.
module tb_main_control_fsm;

  localparam int unsigned T = 4;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] ILL = 6'b111111;

  typedef struct packed {
    logic       pc_write, pc_write_cond, pc_write_ncond, i_or_d, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_op;
    logic       illegal_op, bus_error;
    logic [3:0] state;
  } out_t;

  logic       clock = 1'b0;
  logic       reset, mem_ready;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, pc_write_ncond, i_or_d, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, bus_error;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] alu_op, state;
  out_t       dut_out;

  always #5 clock = ~clock;

  main_control_fsm #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_write_ncond(pc_write_ncond),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_op(alu_op),
    .illegal_op(illegal_op), .bus_error(bus_error), .state(state)
  );

  assign dut_out = {pc_write, pc_write_cond, pc_write_ncond, i_or_d, mem_read, mem_write,
                    ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
                    alu_op, illegal_op, bus_error, state};

  int          n_chk = 0;
  int          n_err = 0;
  int          m_state = 0;
  int unsigned m_wait = 0;
  int          plan[$];
  bit          m_valid = 1'b0;
  out_t        smp;

  logic [5:0] ops [13] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0f,
                           6'h23, 6'h2b, 6'h3f, 6'h03};
  int         lw_seq [5] = '{1, 2, 3, 4, 5};
  int         r_seq [4] = '{1, 2, 7, 8};
  logic [5:0] exi_op [5] = '{6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0f};
  logic [3:0] exi_alu [5] = '{4'b0000, 4'b0110, 4'b0011, 4'b0101, 4'b0100};
  logic [5:0] cur_op;
  int         mw, be, rw;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0f,
                      6'h23, 6'h2b};
  endfunction

  // Remaining states after DECODE for each instruction class.
  task automatic set_plan(input logic [5:0] op);
    plan.delete();
    case (op)
      6'h23:        plan = '{3, 4, 5};
      6'h2b:        plan = '{3, 6};
      6'h00:        plan = '{7, 8};
      6'h04, 6'h05: plan = '{11};
      6'h02:        plan = '{12};
      default:      plan = '{9, 10};
    endcase
  endtask

  function automatic out_t expect_out(input int st, input logic [5:0] op, input logic rdy,
                                      input logic to);
    out_t e;
    e = '0;
    e.state = st[3:0];
    e.bus_error = to;
    case (st)
      1:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
      2:  begin e.alu_src_b = 2'b11; e.illegal_op = !is_legal(op); end
      3:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      4:  begin e.mem_read = 1; e.i_or_d = 1; end
      5:  begin e.reg_write = 1; e.mem_to_reg = 1; end
      6:  begin e.mem_write = !to; e.i_or_d = 1; end
      7:  begin e.alu_src_a = 1; e.alu_op = 4'b0010; end
      8:  begin e.reg_write = 1; e.reg_dst = 1; end
      9:  begin
        e.alu_src_a = 1; e.alu_src_b = 2'b10;
        e.alu_op = (op == 6'h0a) ? 4'b0110 : (op == 6'h0c) ? 4'b0011 :
                   (op == 6'h0d) ? 4'b0101 : (op == 6'h0f) ? 4'b0100 : 4'b0000;
      end
      10: e.reg_write = 1;
      11: begin
        e.alu_src_a = 1; e.alu_op = 4'b0001; e.pc_source = 2'b01;
        e.pc_write_cond = (op == 6'h04); e.pc_write_ncond = (op == 6'h05);
      end
      12: begin e.pc_write = 1; e.pc_source = 2'b10; end
      default: ;
    endcase
    return e;
  endfunction

  // One clock cycle: drive, compare at the falling edge, advance the model.
  task automatic step(input logic rst, input logic [5:0] op, input logic rdy);
    logic to;
    int   nxt;
    reset = rst; opcode = op; mem_ready = rdy;
    @(negedge clock);
    smp = dut_out;
    to = m_valid && (m_state inside {1, 4, 6}) && (m_wait == T - 1) && !rdy;
    if (m_valid) check("outputs", 32'(smp), 32'(expect_out(m_state, op, rdy, to)));
    nxt = m_state;
    if (!rst) begin
      nxt = 0;
      plan.delete();
    end else if (m_valid) begin
      case (m_state)
        0: nxt = 1;
        1: nxt = rdy ? 2 : 1;
        2: begin
          if (is_legal(op)) begin
            set_plan(op);
            nxt = plan.pop_front();
          end else nxt = 1;
        end
        4, 6: begin
          if (to) plan.delete();
          if (rdy || to) nxt = (plan.size() != 0) ? plan.pop_front() : 1;
        end
        default: nxt = (plan.size() != 0) ? plan.pop_front() : 1;
      endcase
    end
    m_wait = (rst && m_valid && nxt == m_state && !to) ? m_wait + 1 : 0;
    m_state = nxt;
    if (!rst) m_valid = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; opcode = LW; mem_ready = 1'b1;
    @(posedge clock);
    #1;
    step(1'b0, LW, 1'b1);
    step(1'b0, LW, 1'b1);

    // Reset state, then lw with memory always ready.
    step(1'b1, LW, 1'b1);
    check("idle_state", 32'(smp.state), 32'd0);
    check("idle_outputs", 32'(smp), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, LW, 1'b1);
      check("lw_state", 32'(smp.state), 32'(lw_seq[i]));
      check("lw_wb", 32'({smp.reg_write, smp.mem_to_reg}), (i == 4) ? 32'd3 : 32'd0);
    end

    // R-type.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, RT, 1'b1);
      check("r_state", 32'(smp.state), 32'(r_seq[i]));
      if (i == 2) check("exr_alu", 32'({smp.alu_op, smp.alu_src_b}), 32'b0010_00);
      if (i == 3) check("rwb_dst_wr", 32'({smp.reg_dst, smp.reg_write}), 32'b11);
    end

    // Immediate ALU ops and branches.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, exi_op[k], 1'b1);
      step(1'b1, exi_op[k], 1'b1);
      step(1'b1, exi_op[k], 1'b1);
      check("exi_state", 32'(smp.state), 32'd9);
      check("exi_alu_op", 32'(smp.alu_op), 32'(exi_alu[k]));
      step(1'b1, exi_op[k], 1'b1);
      check("iwb_state", 32'(smp.state), 32'd10);
    end
    for (int k = 0; k < 2; k++) begin
      cur_op = (k == 0) ? 6'h04 : 6'h05;
      step(1'b1, cur_op, 1'b1);
      step(1'b1, cur_op, 1'b1);
      step(1'b1, cur_op, 1'b1);
      check("branch_cond", 32'({smp.pc_write_cond, smp.pc_write_ncond}),
            (k == 0) ? 32'b10 : 32'b01);
      check("branch_alu_op", 32'(smp.alu_op), 32'd1);
    end

    // sw with a 3-cycle memory stall.
    step(1'b1, SW, 1'b1); step(1'b1, SW, 1'b1); step(1'b1, SW, 1'b1);
    mw = 0; be = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, SW, i == 3);
      mw += int'(smp.mem_write);
      be += int'(smp.bus_error);
    end
    check("sw_write_cycles", 32'(mw), 32'd4);
    check("sw_no_bus_error", 32'(be), 32'd0);

    // lw with memory stuck: timeout on the 4th wait cycle.
    step(1'b1, LW, 1'b1); step(1'b1, LW, 1'b1); step(1'b1, LW, 1'b1);
    rw = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, LW, 1'b0);
      check("timeout_pulse", 32'(smp.bus_error), (i == 3) ? 32'd1 : 32'd0);
      rw += int'(smp.reg_write);
    end
    step(1'b1, ILL, 1'b1);
    check("timeout_to_fetch", 32'(smp.state), 32'd1);
    check("timeout_no_wb", 32'(rw + int'(smp.reg_write)), 32'd0);

    // Illegal opcode, then reset in the middle of a read.
    step(1'b1, ILL, 1'b1);
    check("illegal_pulse", 32'({smp.state, smp.illegal_op}), 32'b0010_1);
    step(1'b1, LW, 1'b1);
    check("illegal_to_fetch", 32'(smp.state), 32'd1);
    step(1'b1, LW, 1'b1); step(1'b1, LW, 1'b1);
    step(1'b0, LW, 1'b0);
    check("memrd_before_reset", 32'({smp.state, smp.mem_read}), 32'b0100_1);
    step(1'b1, LW, 1'b1);
    check("reset_state", 32'(smp.state), 32'd0);
    check("reset_outputs", 32'(smp), 32'd0);

    // Random traffic.
    cur_op = LW;
    for (int n = 0; n < 3000; n++) begin
      if (m_state <= 1) cur_op = ops[$urandom_range(0, 12)];
      step($urandom_range(0, 99) != 0, cur_op, $urandom_range(0, 9) < 6);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
